// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls & Cows guess scorer.
//   bc_state_e : scorer FSM states
//   cnt_width  : width of a counter that must hold 0..n
//   get_digit  : extract digit idx (width dw) from a packed operand vector
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BULLS,
        COWS,
        DONE
    } bc_state_e;

    // Widest operand get_digit accepts (8 digits of up to 32 bits).
    localparam int MAX_VEC_W = 256;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] get_digit(input logic [MAX_VEC_W-1:0] vec,
                                              input int idx,
                                              input int dw);
        logic [MAX_VEC_W-1:0] sh;
        sh = vec >> (idx * dw);
        return sh[31:0] & ((32'd1 << dw) - 32'd1);
    endfunction

endpackage

// File: rtl/bc_guess_scorer_first_match.sv
// Combinational search for the lowest-index secret digit that is still
// unused and equals key.
//   secret : packed secret digits, digit j = [j*DIGIT_W +: DIGIT_W]
//   used   : per-digit consumed flags
//   key    : value being searched for
//   found  : a matching unused digit exists
//   index  : lowest such digit index (0 when not found)
module bc_first_match #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    input  logic [NUM_DIGITS-1:0]         used,
    input  logic [DIGIT_W-1:0]            key,
    output logic                          found,
    output logic [IDX_W-1:0]              index
);

    // Scan from the top down so the lowest matching index is the last written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            if (!used[j] && secret[j*DIGIT_W +: DIGIT_W] == key) begin
                found = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bc_guess_scorer.sv
// Multi-cycle Bulls & Cows evaluator: validates a secret/guess pair one digit
// per cycle, then scores bulls in one cycle and cows one guess digit per cycle.
//   clock, reset (async, active-high), clear (sync abort)
//   start_valid/start_ready : operand handshake (secret, guess)
//   busy                    : evaluation in progress
//   res_valid/res_ready     : result handshake (bulls, cows, win, invalid)
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// CHECK | range / distinctness check, one digit per cycle
// BULLS | exact-position compare of all digits at once
// COWS  | per guess digit, consume lowest matching unused secret digit
// DONE  | result held until res_ready
module bc_guess_scorer
    import bc_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int DIGIT_MAX    = 9,
    parameter int ALLOW_REPEAT = 0,
    localparam int CNT_W       = cnt_width(NUM_DIGITS),
    localparam int VEC_W       = NUM_DIGITS * DIGIT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [VEC_W-1:0] secret,
    input  logic [VEC_W-1:0] guess,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] bulls,
    output logic [CNT_W-1:0] cows,
    output logic             win,
    output logic             invalid
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);
    localparam logic [IDX_W-1:0]   LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]   FULL = CNT_W'(NUM_DIGITS);

    bc_state_e             state, state_n;
    logic [VEC_W-1:0]      sec_q, gss_q;
    logic [IDX_W-1:0]      idx;
    logic                  err_q;
    logic [NUM_DIGITS-1:0] g_used, s_used;
    logic [CNT_W-1:0]      bulls_cnt, cows_cnt;

    logic [DIGIT_W-1:0]    sec_d, gss_d;
    logic                  digit_err, last_idx, cow_hit, err_nxt;
    logic [NUM_DIGITS-1:0] bull_vec;
    logic [CNT_W-1:0]      bull_pop, cows_nxt;
    logic                  fm_found;
    logic [IDX_W-1:0]      fm_idx;

    function automatic logic [DIGIT_W-1:0] dig(input logic [VEC_W-1:0] v, input int i);
        return DIGIT_W'(get_digit(MAX_VEC_W'(v), i, DIGIT_W));
    endfunction

    assign sec_d    = dig(sec_q, int'(idx));
    assign gss_d    = dig(gss_q, int'(idx));
    assign last_idx = (idx == LAST);

    // Digit idx is compared only against lower indices, so each pair is
    // examined exactly once across the CHECK pass.
    always_comb begin
        digit_err = (sec_d > DMAX) || (gss_d > DMAX);
        if (ALLOW_REPEAT == 0) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (IDX_W'(j) < idx &&
                    (dig(sec_q, j) == sec_d || dig(gss_q, j) == gss_d))
                    digit_err = 1'b1;
            end
        end
    end

    always_comb begin
        bull_pop = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bull_vec[i] = (dig(sec_q, i) == dig(gss_q, i));
            bull_pop    = bull_pop + CNT_W'(bull_vec[i]);
        end
    end

    bc_first_match #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_first_match (
        .secret (sec_q),
        .used   (s_used),
        .key    (gss_d),
        .found  (fm_found),
        .index  (fm_idx)
    );

    assign cow_hit  = (state == COWS) && !g_used[idx] && fm_found;
    assign err_nxt  = err_q | ((state == CHECK) && digit_err);
    assign cows_nxt = cows_cnt + CNT_W'(cow_hit);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_valid) state_n = CHECK;
            CHECK:   if (last_idx)    state_n = err_nxt ? DONE : BULLS;
            BULLS:                    state_n = COWS;
            COWS:    if (last_idx)    state_n = DONE;
            DONE:    if (res_ready)   state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            bulls       <= '0;
            cows        <= '0;
            win         <= 1'b0;
            invalid     <= 1'b0;
            sec_q       <= '0;
            gss_q       <= '0;
            idx         <= '0;
            err_q       <= 1'b0;
            g_used      <= '0;
            s_used      <= '0;
            bulls_cnt   <= '0;
            cows_cnt    <= '0;
        end else begin
            state       <= state_n;
            start_ready <= (state_n == IDLE);
            busy        <= (state_n inside {CHECK, BULLS, COWS});
            res_valid   <= (state_n == DONE);

            if (clear) begin
                idx       <= '0;
                err_q     <= 1'b0;
                g_used    <= '0;
                s_used    <= '0;
                bulls_cnt <= '0;
                cows_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: if (start_valid) begin
                        sec_q     <= secret;
                        gss_q     <= guess;
                        idx       <= '0;
                        err_q     <= 1'b0;
                        g_used    <= '0;
                        s_used    <= '0;
                        bulls_cnt <= '0;
                        cows_cnt  <= '0;
                    end
                    CHECK: begin
                        err_q <= err_nxt;
                        idx   <= last_idx ? '0 : idx + 1'b1;
                    end
                    BULLS: begin
                        g_used    <= bull_vec;
                        s_used    <= bull_vec;
                        bulls_cnt <= bull_pop;
                    end
                    COWS: begin
                        if (cow_hit) s_used[fm_idx] <= 1'b1;
                        cows_cnt <= cows_nxt;
                        idx      <= last_idx ? '0 : idx + 1'b1;
                    end
                    default: ;
                endcase

                // Result registers load on DONE entry using this cycle's
                // final error/cow contributions, so they are settled when
                // res_valid rises.
                if (state != DONE && state_n == DONE) begin
                    invalid <= err_nxt;
                    bulls   <= err_nxt ? '0 : bulls_cnt;
                    cows    <= err_nxt ? '0 : cows_nxt;
                    win     <= !err_nxt && (bulls_cnt == FULL);
                end
            end
        end
    end

endmodule

// File: tb/tb_bc_guess_scorer.sv
// Directed bench for bc_guess_scorer: one instance without repeats
// (dut0) and one with repeats allowed (dut1), sharing clock, reset, clear,
// operands and res_ready.
module tb_bc_guess_scorer;

    logic        clock = 1'b0;
    logic        reset, clear, sv0, sv1, res_ready;
    logic [15:0] secret, guess;

    logic       sr0, busy0, rv0, win0, inv0;
    logic       sr1, busy1, rv1, win1, inv1;
    logic [2:0] b0, c0, b1, c1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bc_guess_scorer #(.ALLOW_REPEAT(0)) dut0 (
        .clock(clock), .reset(reset), .clear(clear),
        .start_valid(sv0), .start_ready(sr0),
        .secret(secret), .guess(guess),
        .busy(busy0), .res_valid(rv0), .res_ready(res_ready),
        .bulls(b0), .cows(c0), .win(win0), .invalid(inv0)
    );

    bc_guess_scorer #(.ALLOW_REPEAT(1)) dut1 (
        .clock(clock), .reset(reset), .clear(clear),
        .start_valid(sv1), .start_ready(sr1),
        .secret(secret), .guess(guess),
        .busy(busy1), .res_valid(rv1), .res_ready(res_ready),
        .bulls(b1), .cows(c1), .win(win1), .invalid(inv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input int inst, input logic [15:0] s, input logic [15:0] g);
        @(negedge clock);
        secret = s;
        guess  = g;
        if (inst == 0) sv0 = 1'b1; else sv1 = 1'b1;
        @(posedge clock);
        #1;
        sv0 = 1'b0;
        sv1 = 1'b0;
        secret = 16'hFFFF;
        guess  = 16'hEEEE;
    endtask

    task automatic wait_res(input int inst, input int elat, input string tag);
        int n = 0;
        while ((inst == 0 ? rv0 : rv1) !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, elat);
    endtask

    task automatic chk_res(input int inst, input string tag,
                           input int eb, input int ec, input int ew, input int ei);
        chk({tag, "_bulls"},   inst == 0 ? b0 : b1, eb);
        chk({tag, "_cows"},    inst == 0 ? c0 : c1, ec);
        chk({tag, "_win"},     inst == 0 ? win0 : win1, ew);
        chk({tag, "_invalid"}, inst == 0 ? inv0 : inv1, ei);
    endtask

    task automatic ack(input int inst, input string tag);
        @(negedge clock);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        chk({tag, "_rv_drop"}, inst == 0 ? rv0 : rv1, 0);
        chk({tag, "_sr_back"}, inst == 0 ? sr0 : sr1, 1);
    endtask

    task automatic run(input int inst, input string tag,
                       input logic [15:0] s, input logic [15:0] g,
                       input int elat, input int eb, input int ec,
                       input int ew, input int ei);
        start(inst, s, g);
        wait_res(inst, elat, tag);
        chk_res(inst, tag, eb, ec, ew, ei);
        ack(inst, tag);
    endtask

    initial begin
        int bad;
        int seen;

        reset = 1'b1; clear = 1'b0; sv0 = 1'b0; sv1 = 1'b0;
        res_ready = 1'b0; secret = '0; guess = '0;
        #12;
        chk("rst_sr",    sr0, 1);
        chk("rst_busy",  busy0, 0);
        chk("rst_rv",    rv0, 0);
        chk("rst_bulls", b0, 0);
        chk("rst_cows",  c0, 0);
        chk("rst_win",   win0, 0);
        chk("rst_inv",   inv0, 0);
        @(negedge clock);
        reset = 1'b0;

        // Distinct-digit scoring, valid latency 2N+1.
        run(0, "exact",   16'h1234, 16'h1234, 9, 4, 0, 1, 0);
        run(0, "reverse", 16'h1234, 16'h4321, 9, 0, 4, 0, 0);
        run(0, "mixed",   16'h1234, 16'h1243, 9, 2, 2, 0, 0);
        run(0, "none",    16'h1234, 16'h5678, 9, 0, 0, 0, 0);

        // Invalid operands finish after the CHECK pass (N cycles).
        run(0, "rep_guess", 16'h1234, 16'h1123, 4, 0, 0, 0, 1);
        run(0, "range_sec", 16'h12A4, 16'h1234, 4, 0, 0, 0, 1);

        // Repeats allowed: multiset cow counting.
        run(1, "r_swap",  16'h1122, 16'h2211, 9, 0, 4, 0, 0);
        run(1, "r_multi", 16'h1123, 16'h1111, 9, 2, 0, 0, 0);
        run(1, "r_range", 16'h1B22, 16'h1122, 4, 0, 0, 0, 1);

        // Backpressure: hold the result while start_valid toggles.
        start(0, 16'h1234, 16'h1243);
        wait_res(0, 9, "bp");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            sv0 = ~sv0;
            secret = 16'(i);
            @(posedge clock);
            #1;
            if (rv0 !== 1'b1 || b0 !== 3'd2 || c0 !== 3'd2 || sr0 !== 1'b0 || busy0 !== 1'b0)
                bad++;
        end
        sv0 = 1'b0;
        chk("bp_hold_bad_cycles", bad, 0);
        ack(0, "bp");
        chk("bp_bulls_kept", b0, 2);
        run(0, "after_bp", 16'h5678, 16'h5687, 9, 2, 2, 0, 0);

        // clear during the third COWS cycle.
        start(0, 16'h1234, 16'h4321);
        repeat (7) @(posedge clock);
        #1;
        chk("clr_busy_before", busy0, 1);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("clr_busy", busy0, 0);
        chk("clr_sr",   sr0, 1);
        chk("clr_rv",   rv0, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (rv0 === 1'b1) seen++;
        end
        chk("clr_no_result", seen, 0);

        // clear together with start_valid in IDLE suppresses the accept.
        @(negedge clock);
        sv0 = 1'b1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        sv0 = 1'b0;
        clear = 1'b0;
        chk("clr_start_sr",   sr0, 1);
        chk("clr_start_busy", busy0, 0);

        // Async reset while in CHECK.
        start(0, 16'h1234, 16'h1234);
        @(posedge clock);
        #2;
        chk("rst_mid_busy_before", busy0, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_sr",   sr0, 1);
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_rv",   rv0, 0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (rv0 === 1'b1) seen++;
        end
        chk("rst_mid_no_result", seen, 0);
        run(0, "after_rst", 16'h9876, 16'h9876, 9, 4, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
